rv32i_lsu: RTL
==============

// Module: rv32i_lsu
// PURPOSE
//  Load/store unit of the multicycle RV32I core. It sits directly downstream of decode and execute.
//  It consumes the decoded memory_op_t / memory_size_t, the ALU-computed address and rs2.
//  It runs one data-memory transaction over a req/gnt/rvalid bus and returns aligned,
//  sign/zero-extended load data to writeback, with a done pulse to the core controller.
// PARAMETERS
//  ADDR_W   32  byte-address width of i_addr / o_dmem_addr
// PORTS
//  clk            in   1       core clock; all state rising-edge
//  rst_n          in   1       asynchronous, active-low reset
//  i_start        in   1       1-cycle pulse: begin memory phase; sampled only in IDLE
//  i_mem_op       in   2       memory_op_t (MEM_NOOP/LOAD/STORE)
//  i_mem_size     in   2       memory_size_t (BYTE/HALF_WORD/WORD); 2'b11 illegal
//  i_unsigned     in   1       funct3[2]: LBU/LHU zero-extend
//  i_addr         in   ADDR_W  effective byte address (rs1+imm)
//  i_store_data   in   32      rs2 value
//  o_busy         out  1       high in any state but IDLE
//  o_done         out  1       1-cycle completion pulse
//  o_misaligned   out  1       valid with o_done: access was misaligned/illegal, no bus cycle
//  o_load_data    out  32      extended load result; held until next load completes
//  o_dmem_req     out  1       bus request
//  o_dmem_we      out  1       1=store
//  o_dmem_addr    out  ADDR_W  word-aligned address ({i_addr[ADDR_W-1:2],2'b00})
//  o_dmem_be      out  4       byte enables
//  o_dmem_wdata   out  32      lane-replicated store data
//  i_dmem_gnt     in   1       request accepted this cycle
//  i_dmem_rvalid  in   1       read data valid
//  i_dmem_rdata   in   32      read word
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (incl. o_load_data); captured addr/size/data cleared.
//  - FSM states IDLE, REQ, WAIT, DONE.
//    IDLE--i_start, op LOAD/STORE, aligned-->REQ. Latch addr[1:0], size, unsigned, op.
//    IDLE--i_start, MEM_NOOP-->DONE with o_misaligned=0 and no bus activity.
//    IDLE--i_start, misaligned/illegal-->DONE with o_misaligned=1 and no bus activity.
//    REQ: o_dmem_req=1. On i_dmem_gnt: STORE-->DONE, LOAD-->WAIT.
//    WAIT: on i_dmem_rvalid, capture the extended data into o_load_data, then -->DONE.
//    DONE: o_done=1 for exactly one cycle, then -->IDLE.
//  - o_dmem_* are registered, set on IDLE->REQ, and held stable while req=1 without gnt.
//    They drop to 0 the cycle after gnt.
//  - Misaligned: HALF_WORD with addr[0]=1; WORD with addr[1:0]!=0; size 2'b11 always.
//  - Byte enables: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<a[1:0]; WORD 4'b1111.
//  - Store data: BYTE {4{d[7:0]}}; HALF {2{d[15:0]}}; WORD d.
//  - Load extract: lane = rdata >> (8*a[1:0]). BYTE/HALF are sign-extended unless i_unsigned=1.
//  - Latency from i_start with 0-wait bus:
//    Store: gnt in the first REQ cycle; o_done 2 cycles after i_start.
//    Load: gnt, then rvalid the next cycle; o_done 3 cycles after i_start.
//    MEM_NOOP and misaligned: o_done 1 cycle after i_start.
//  - i_start while o_busy=1 is ignored.
//  - i_dmem_rvalid outside WAIT is ignored. rvalid coincident with gnt is not honoured.
//  - Unbounded gnt/rvalid stall is permitted; the FSM simply waits.
//  - rst_n low mid-transaction aborts immediately to IDLE, clears all outputs, and emits no o_done.
// STRUCTURE
//  - Add to RV32I_core_utils_package: lsu_state_t enum {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE}.
//  - Add byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
//  - Sub-module rv32i_lsu_align (combinational): misalign check, byte enables,
//    store replication, load extract/extend. rv32i_lsu holds the FSM and registers.
// TESTING
//  1 SW addr 0x100, d=0xDEADBEEF, gnt in first REQ cycle:
//    req with we=1, be=1111, wdata=0xDEADBEEF; o_done at start+2.
//  2 LB addr 0x103, rdata=0x80FF_FF7F:
//    be=1000, o_load_data=0xFFFFFF80; the LBU variant gives 0x00000080.
//  3 LH addr 0x102, rdata=0x8001_0000:
//    o_load_data=0xFFFF8001; SH addr 0x102, d=0x1234ABCD gives be=1100, wdata=0xABCDABCD.
//  4 LW addr 0x101:
//    no req; o_done and o_misaligned at start+1; o_load_data unchanged.
//  5 LW with gnt held low 3 cycles, then rvalid 2 cycles after gnt:
//    addr/be/we stable throughout; single o_done; i_start pulses while busy ignored.
//  6 rst_n low while in WAIT:
//    all outputs 0 and no o_done; a following SB addr 0x001 runs cleanly with be=0010.

Source files
------------

// File: rtl/rv32i_lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : RV32I_core_utils_package
//  Purpose  : Shared types and constants for the RV32I multicycle core.
//             Holds the decoded memory-op / memory-size encodings, the
//             load/store unit state type and the byte-enable base patterns.
//  Ports    : none (package)
//  Revision : 1.0 - initial load/store unit types
// ============================================================================
package RV32I_core_utils_package;

    // Decoded memory operation driven by the decode stage.
    typedef enum logic [1:0] {
        MEM_NOOP  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } memory_op_t;

    // Access width; 2'b11 is not a legal RV32I size.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } memory_size_t;

    // Load/store unit control states.
    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    // Byte-enable base patterns, shifted by the byte offset for sub-word accesses.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : RV32I_core_utils_package
`default_nettype wire

// File: rtl/rv32i_lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv32i_lsu_align
//  Purpose  : Purely combinational data-path helper of the load/store unit.
//             Checks alignment, builds byte enables, replicates store data
//             across byte lanes and extracts/extends load data.
//  Ports    : i_size        access size (memory_size_t encoding)
//             i_offset      byte offset within the word (addr[1:0])
//             i_unsigned    zero-extend sub-word loads when set
//             i_store_data  rs2 value
//             i_rdata       word returned by data memory
//             o_misaligned  access is misaligned or the size is illegal
//             o_be          byte enables for the bus
//             o_wdata       lane-replicated store data
//             o_load_data   aligned, extended load result
//  Revision : 1.0 - initial version
// ============================================================================
module rv32i_lsu_align
    import RV32I_core_utils_package::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic        o_misaligned,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;

    // Lane selection; a half-word access is only ever issued aligned, so
    // offset[1] alone picks its lane.
    always_comb begin
        case (i_offset)
            2'd0:    w_byte_lane = i_rdata[7:0];
            2'd1:    w_byte_lane = i_rdata[15:8];
            2'd2:    w_byte_lane = i_rdata[23:16];
            default: w_byte_lane = i_rdata[31:24];
        endcase
        w_half_lane = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_misaligned = 1'b0;
        o_be         = 4'b0000;
        o_wdata      = i_store_data;
        o_load_data  = i_rdata;
        case (i_size)
            BYTE: begin
                o_be        = BE_BYTE << i_offset;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{w_byte_lane[7] & ~i_unsigned}}, w_byte_lane};
            end
            HALF_WORD: begin
                o_misaligned = i_offset[0];
                o_be         = BE_HALF << i_offset;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_half_lane[15] & ~i_unsigned}}, w_half_lane};
            end
            WORD: begin
                o_misaligned = |i_offset;
                o_be         = BE_WORD;
            end
            default: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule : rv32i_lsu_align
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv32i_lsu
//  Purpose  : Load/store unit of the multicycle RV32I core. Runs a single
//             data-memory transaction over a req/gnt/rvalid bus and returns
//             aligned, extended load data with a one-cycle done pulse.
//  Ports    : clk, rst_n            clock, asynchronous active-low reset
//             i_start               begin memory phase (sampled in IDLE only)
//             i_mem_op, i_mem_size  decoded operation and access size
//             i_unsigned            zero-extend LBU/LHU
//             i_addr, i_store_data  effective address and rs2
//             o_busy, o_done        status / completion pulse
//             o_misaligned          valid with o_done, no bus cycle issued
//             o_load_data           extended load result, held until next load
//             o_dmem_*              registered request side of the bus
//             i_dmem_gnt/rvalid/rdata  bus responses
//  Revision : 1.0 - initial version
// ============================================================================
module rv32i_lsu
    import RV32I_core_utils_package::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mem_op,
    input  logic [1:0]        i_mem_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_misaligned,
    output logic [31:0]       o_load_data,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic              mis_q, mis_d;
    logic [31:0]       ld_q, ld_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              w_idle;
    logic [1:0]        w_size;
    logic [1:0]        w_offset;
    logic              w_unsigned;
    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_data;

    // One align instance serves both phases: in IDLE it sees the live
    // request (for checking and bus setup), afterwards the latched one (for
    // load extraction), since the decode inputs may change once busy.
    assign w_idle     = (state_q == LSU_IDLE);
    assign w_size     = w_idle ? i_mem_size  : size_q;
    assign w_offset   = w_idle ? i_addr[1:0] : off_q;
    assign w_unsigned = w_idle ? i_unsigned  : uns_q;

    rv32i_lsu_align u_align (
        .i_size       (w_size),
        .i_offset     (w_offset),
        .i_unsigned   (w_unsigned),
        .i_store_data (i_store_data),
        .i_rdata      (i_dmem_rdata),
        .o_misaligned (w_misaligned),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        mis_d   = mis_q;
        ld_d    = ld_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (i_start) begin
                    op_d   = i_mem_op;
                    size_d = i_mem_size;
                    uns_d  = i_unsigned;
                    off_d  = i_addr[1:0];
                    if ((i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE)) begin
                        if (w_misaligned) begin
                            // Rejected before any bus activity.
                            mis_d   = 1'b1;
                            state_d = LSU_DONE;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = (i_mem_op == MEM_STORE);
                            addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                            be_d    = w_be;
                            wdata_d = (i_mem_op == MEM_STORE) ? w_wdata : 32'd0;
                            state_d = LSU_REQ;
                        end
                    end else begin
                        state_d = LSU_DONE;
                    end
                end
            end
            LSU_REQ: begin
                // Bus fields stay frozen until the grant, then clear together.
                if (i_dmem_gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = 4'b0000;
                    wdata_d = 32'd0;
                    state_d = (op_q == MEM_STORE) ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (i_dmem_rvalid) begin
                    ld_d    = w_load_data;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                mis_d   = 1'b0;
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            op_q    <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            mis_q   <= 1'b0;
            ld_q    <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            mis_q   <= mis_d;
            ld_q    <= ld_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_busy       = (state_q != LSU_IDLE);
    assign o_done       = (state_q == LSU_DONE);
    assign o_misaligned = mis_q;
    assign o_load_data  = ld_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;

endmodule : rv32i_lsu
`default_nettype wire
